// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update controller: geometry, entry layout, FSM encoding.
package btb_pkg;
    localparam int PC_W        = 17;
    localparam int IDX_W       = 5;
    localparam int TAG_W       = PC_W - IDX_W - 2;
    localparam int ENTRY_W     = 1 + TAG_W + PC_W;
    localparam int NUM_ENTRIES = 2 ** IDX_W;
    localparam int CNT_W       = 8;

    localparam int TGT_LSB   = 0;
    localparam int TAG_LSB   = PC_W;
    localparam int VALID_BIT = PC_W + TAG_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        entry_t           entry;
    } upd_t;

    function automatic entry_t make_entry(input logic v, input logic [TAG_W-1:0] tag,
                                          input logic [PC_W-1:0] tgt);
        entry_t e;
        e = '0;
        e[VALID_BIT]                 = v;
        e[TAG_LSB +: TAG_W]          = tag;
        e[TGT_LSB +: PC_W]           = tgt;
        return e;
    endfunction
endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolution, config, flush and BTB write-port signals of the BTB update controller.
interface btb_update_ctrl_if;
    import btb_pkg::*;

    logic              res_valid;
    logic [PC_W-1:0]   res_pc;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              res_hit;
    logic              cfg_valid;
    logic [IDX_W-1:0]  cfg_addr;
    entry_t            cfg_wd;
    logic              cfg_ready;
    logic              flush_req;
    logic              flush_busy;
    logic              btb_we;
    logic [IDX_W-1:0]  btb_waddr;
    entry_t            btb_wd;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output res_valid, res_pc, res_taken, res_target, res_hit,
        output cfg_valid, cfg_addr, cfg_wd, flush_req,
        input  cfg_ready, flush_busy, btb_we, btb_waddr, btb_wd, drop_cnt
    );

    modport slave (
        input  res_valid, res_pc, res_taken, res_target, res_hit,
        input  cfg_valid, cfg_addr, cfg_wd, flush_req,
        output cfg_ready, flush_busy, btb_we, btb_waddr, btb_wd, drop_cnt
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// Small FIFO for pending BTB updates; pointers carry an extra wrap bit to tell full from empty.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// Owns the BTB write port: arbitrates flush sweep, config writes and queued branch updates.
//   state | meaning
//   IDLE  | serve cfg write, else queued update, else idle
//   SWEEP | invalidate one entry per cycle, idx 0 .. NUM_ENTRIES-1
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int QDEPTH         = 4,
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              rst,
    btb_update_ctrl_if.slave bus
);
    localparam state_t RST_STATE = FLUSH_ON_RESET ? SWEEP : IDLE;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              we_q;
    logic [IDX_W-1:0]  waddr_q;
    entry_t            wd_q;
    logic [CNT_W-1:0]  drop_q;

    upd_t  upd;
    upd_t  q_head;
    logic  upd_valid;
    logic  idle_live;
    logic  pop;
    logic  bypass;
    logic  push_req;
    logic  push;
    logic  drop;
    logic  q_clear;
    logic  q_full;
    logic  q_empty;

    always_comb begin
        upd_valid = bus.res_valid && (bus.res_taken || bus.res_hit);
        upd.idx   = bus.res_pc[IDX_W+1:2];
        upd.entry = bus.res_taken ? make_entry(1'b1, bus.res_pc[PC_W-1:IDX_W+2], bus.res_target)
                                  : '0;
    end

    // An update arriving at an empty queue with the port free skips the FIFO,
    // so a lone update is visible on the write port one cycle after resolution.
    assign idle_live = (state == IDLE) && !bus.flush_req;
    assign pop       = idle_live && !bus.cfg_valid && !q_empty;
    assign bypass    = idle_live && !bus.cfg_valid && q_empty && upd_valid;
    assign push_req  = idle_live && upd_valid && !bypass;
    assign push      = push_req && (!q_full || pop);
    assign drop      = push_req && q_full && !pop;
    assign q_clear   = (state == IDLE) && bus.flush_req;

    btb_upd_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(upd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (q_clear),
        .push  (push),
        .pop   (pop),
        .wdata (upd),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            idx     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wd_q    <= '0;
            drop_q  <= '0;
        end else begin
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state <= SWEEP;
                        idx   <= '0;
                        we_q  <= 1'b0;
                    end else if (bus.cfg_valid) begin
                        we_q    <= 1'b1;
                        waddr_q <= bus.cfg_addr;
                        wd_q    <= bus.cfg_wd;
                    end else if (pop) begin
                        we_q    <= 1'b1;
                        waddr_q <= q_head.idx;
                        wd_q    <= q_head.entry;
                    end else if (bypass) begin
                        we_q    <= 1'b1;
                        waddr_q <= upd.idx;
                        wd_q    <= upd.entry;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    we_q    <= 1'b1;
                    waddr_q <= idx;
                    wd_q    <= '0;
                    idx     <= idx + 1'b1;
                    if (&idx) begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btb_we     = we_q;
    assign bus.btb_waddr  = waddr_q;
    assign bus.btb_wd     = wd_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.flush_busy = (state == SWEEP);
    assign bus.cfg_ready  = (state == IDLE);
endmodule
